// File: rtl/mul_writeback.sv
// mul_writeback: registers an 8x8 unsigned multiply and writes the 16-bit
// product back through a single 8-bit register-file port (low byte, then high
// byte), then pulses done and updates the multiply flags.

// Purely combinational 8x8 unsigned multiplier; the product is registered downstream.
module int8_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mul_writeback #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [7:0]            op_a,
  input  logic [7:0]            op_b,
  input  logic [REG_ADDR_W-1:0] dst_lo,
  input  logic [REG_ADDR_W-1:0] dst_hi,
  input  logic                  rf_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [7:0]            rf_wdata,
  output logic                  done,
  output logic                  flag_z,
  output logic                  flag_v
);

  typedef enum logic [2:0] {IDLE, MUL, WR_LO, WR_HI, DONE} state_t;

  // Operation request captured at the accept edge.
  typedef struct packed {
    logic [7:0]            a;
    logic [7:0]            b;
    logic [REG_ADDR_W-1:0] dst_lo;
    logic [REG_ADDR_W-1:0] dst_hi;
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] prod_q, prod_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_v_q, flag_v_d;
  logic [15:0] mul_p;

  // The multiplier sees only the latched operands, so its whole path sits
  // between the operand registers and prod_q.
  int8_multiplier u_mul (
    .a (op_q.a),
    .b (op_q.b),
    .p (mul_p)
  );

  // State register and datapath registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      prod_q   <= '0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
    end
  end

  // Next-state and register updates; flags change only on the edge entering DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    prod_d   = prod_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          op_d.a      = op_a;
          op_d.b      = op_b;
          op_d.dst_lo = dst_lo;
          op_d.dst_hi = dst_hi;
          state_d     = MUL;
        end
      end
      MUL: begin
        prod_d  = mul_p;
        state_d = WR_LO;
      end
      WR_LO: begin
        if (!rf_stall) state_d = WR_HI;
      end
      WR_HI: begin
        if (!rf_stall) begin
          state_d  = DONE;
          flag_z_d = (prod_q == 16'h0000);
          flag_v_d = |prod_q[15:8];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so a stall simply holds them steady.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      WR_LO: begin
        rf_we    = 1'b1;
        rf_waddr = op_q.dst_lo;
        rf_wdata = prod_q[7:0];
      end
      WR_HI: begin
        rf_we    = 1'b1;
        rf_waddr = op_q.dst_hi;
        rf_wdata = prod_q[15:8];
      end
      default: ;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign flag_z      = flag_z_q;
  assign flag_v      = flag_v_q;

endmodule

// File: tb/tb_mul_writeback.sv
// Self-checking bench for mul_writeback: directed scenarios plus randomized
// operations compared against a cycle-schedule reference model.
module tb_mul_writeback;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [7:0]    op_a, op_b;
  logic [AW-1:0] dst_lo, dst_hi;
  logic          rf_stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [7:0]    rf_wdata;
  logic          done, flag_z, flag_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Flags the model expects to be held from the last completed operation.
  logic prev_fz = 1'b0;
  logic prev_fv = 1'b0;

  // Per-cycle observations of one operation; index k = cycles after the accept edge.
  logic          obs_we   [0:31];
  logic [AW-1:0] obs_addr [0:31];
  logic [7:0]    obs_data [0:31];
  logic          obs_done [0:31];
  logic          obs_rdy  [0:31];
  logic          obs_fz   [0:31];
  logic          obs_fv   [0:31];

  mul_writeback #(.REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .dst_lo(dst_lo), .dst_hi(dst_hi),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .flag_z(flag_z), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Issue one operation from idle and record outputs for a fixed number of cycles.
  // rf_stall is asserted for sl cycles of the low write and sh of the high write.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [AW-1:0] dl, input logic [AW-1:0] dh,
                       input int sl, input int sh);
    int nc;
    nc = 6 + sl + sh;
    @(negedge clk);
    obs_we[0] = rf_we; obs_addr[0] = rf_waddr; obs_data[0] = rf_wdata;
    obs_done[0] = done; obs_rdy[0] = start_ready; obs_fz[0] = flag_z; obs_fv[0] = flag_v;
    start_valid = 1'b1; op_a = a; op_b = b; dst_lo = dl; dst_hi = dh; rf_stall = 1'b0;
    for (int k = 1; k <= nc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_valid = 1'b0;
        op_a = 8'($urandom); op_b = 8'($urandom);
        dst_lo = AW'($urandom); dst_hi = AW'($urandom);
      end
      obs_we[k] = rf_we; obs_addr[k] = rf_waddr; obs_data[k] = rf_wdata;
      obs_done[k] = done; obs_rdy[k] = start_ready; obs_fz[k] = flag_z; obs_fv[k] = flag_v;
      rf_stall = ((k >= 2) && (k <= 1 + sl)) || ((k >= 3 + sl) && (k <= 2 + sl + sh));
    end
    rf_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; dst_lo = 3; dst_hi = 5; rf_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", start_ready); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", rf_we); end
      n_checks++; if (rf_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %h exp 0", rf_waddr); end
      n_checks++; if (rf_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h exp 0", rf_wdata); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
      n_checks++; if (flag_z !== 1'b0 || flag_v !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got z=%b v=%b exp 0 0", flag_z, flag_v); end
    end
    rst = 1'b0; start_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b exp 1", start_ready); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b exp 0", rf_we); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b exp 0", done); end
    end
    prev_fz = 1'b0; prev_fv = 1'b0;
  endtask

  task automatic test_basic();
    do_op(8'd200, 8'd3, 3'd1, 3'd2, 0, 0);
    n_checks++; if (obs_rdy[1] !== 1'b0 || obs_we[1] !== 1'b0) begin n_fail++; $display("FAIL basic_mul_cycle: got rdy=%b we=%b exp 0 0", obs_rdy[1], obs_we[1]); end
    n_checks++; if (obs_we[2] !== 1'b1 || obs_addr[2] !== 3'd1) begin n_fail++; $display("FAIL basic_lo_addr: got we=%b addr=%0d exp 1 1", obs_we[2], obs_addr[2]); end
    n_checks++; if (obs_data[2] !== 8'h58) begin n_fail++; $display("FAIL basic_lo_data: got %h exp 58", obs_data[2]); end
    n_checks++; if (obs_we[3] !== 1'b1 || obs_addr[3] !== 3'd2) begin n_fail++; $display("FAIL basic_hi_addr: got we=%b addr=%0d exp 1 2", obs_we[3], obs_addr[3]); end
    n_checks++; if (obs_data[3] !== 8'h02) begin n_fail++; $display("FAIL basic_hi_data: got %h exp 02", obs_data[3]); end
    n_checks++; if (obs_done[3] !== 1'b0 || obs_done[4] !== 1'b1 || obs_done[5] !== 1'b0) begin n_fail++; $display("FAIL basic_done: got %b%b%b exp 010", obs_done[3], obs_done[4], obs_done[5]); end
    n_checks++; if (obs_we[4] !== 1'b0) begin n_fail++; $display("FAIL basic_done_we: got %b exp 0", obs_we[4]); end
    n_checks++; if (obs_fz[4] !== 1'b0 || obs_fv[4] !== 1'b1) begin n_fail++; $display("FAIL basic_flags: got z=%b v=%b exp 0 1", obs_fz[4], obs_fv[4]); end
    n_checks++; if (obs_rdy[4] !== 1'b0 || obs_rdy[5] !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b%b exp 01", obs_rdy[4], obs_rdy[5]); end
    prev_fz = 1'b0; prev_fv = 1'b1;
  endtask

  task automatic test_zero_max();
    do_op(8'h00, 8'hA5, 3'd3, 3'd5, 0, 0);
    n_checks++; if (obs_data[2] !== 8'h00 || obs_data[3] !== 8'h00) begin n_fail++; $display("FAIL zero_data: got %h %h exp 00 00", obs_data[2], obs_data[3]); end
    n_checks++; if (obs_fz[3] !== prev_fz || obs_fv[3] !== prev_fv) begin n_fail++; $display("FAIL zero_flag_hold: got z=%b v=%b exp %b %b", obs_fz[3], obs_fv[3], prev_fz, prev_fv); end
    n_checks++; if (obs_fz[4] !== 1'b1 || obs_fv[4] !== 1'b0) begin n_fail++; $display("FAIL zero_flags: got z=%b v=%b exp 1 0", obs_fz[4], obs_fv[4]); end
    prev_fz = 1'b1; prev_fv = 1'b0;
    do_op(8'hFF, 8'hFF, 3'd6, 3'd7, 0, 0);
    n_checks++; if (obs_data[2] !== 8'h01 || obs_data[3] !== 8'hFE) begin n_fail++; $display("FAIL max_data: got %h %h exp 01 fe", obs_data[2], obs_data[3]); end
    n_checks++; if (obs_addr[2] !== 3'd6 || obs_addr[3] !== 3'd7) begin n_fail++; $display("FAIL max_addr: got %0d %0d exp 6 7", obs_addr[2], obs_addr[3]); end
    n_checks++; if (obs_fz[3] !== 1'b1 || obs_fv[3] !== 1'b0) begin n_fail++; $display("FAIL max_flag_hold: got z=%b v=%b exp 1 0", obs_fz[3], obs_fv[3]); end
    n_checks++; if (obs_fz[4] !== 1'b0 || obs_fv[4] !== 1'b1) begin n_fail++; $display("FAIL max_flags: got z=%b v=%b exp 0 1", obs_fz[4], obs_fv[4]); end
    prev_fz = 1'b0; prev_fv = 1'b1;
  endtask

  task automatic test_stall();
    do_op(8'd15, 8'd17, 3'd5, 3'd6, 3, 1);
    for (int k = 2; k <= 5; k++) begin
      n_checks++; if (obs_we[k] !== 1'b1 || obs_addr[k] !== 3'd5 || obs_data[k] !== 8'hFF) begin n_fail++; $display("FAIL stall_lo[%0d]: got we=%b addr=%0d data=%h exp 1 5 ff", k, obs_we[k], obs_addr[k], obs_data[k]); end
    end
    for (int k = 6; k <= 7; k++) begin
      n_checks++; if (obs_we[k] !== 1'b1 || obs_addr[k] !== 3'd6 || obs_data[k] !== 8'h00) begin n_fail++; $display("FAIL stall_hi[%0d]: got we=%b addr=%0d data=%h exp 1 6 00", k, obs_we[k], obs_addr[k], obs_data[k]); end
    end
    n_checks++; if (obs_done[7] !== 1'b0 || obs_done[8] !== 1'b1 || obs_we[8] !== 1'b0) begin n_fail++; $display("FAIL stall_done: got done7=%b done8=%b we8=%b exp 0 1 0", obs_done[7], obs_done[8], obs_we[8]); end
    n_checks++; if (obs_fz[8] !== 1'b0 || obs_fv[8] !== 1'b0) begin n_fail++; $display("FAIL stall_flags: got z=%b v=%b exp 0 0", obs_fz[8], obs_fv[8]); end
    prev_fz = 1'b0; prev_fv = 1'b0;
  endtask

  // Hold start_valid high with fresh operands every cycle; only ops seen while
  // start_ready is high may appear in the writeback stream.
  task automatic test_back_to_back();
    logic [7:0]    qa[$], qb[$];
    logic [AW-1:0] ql[$], qh[$];
    int            qc[$];
    logic          bw[0:23];
    logic [AW-1:0] baddr[0:23];
    logic [7:0]    bdata[0:23];
    logic          bdone[0:23], bfz[0:23], bfv[0:23];
    logic [15:0]   p;
    logic          ew, ed;
    logic [AW-1:0] ea;
    logic [7:0]    edat;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bw[c] = rf_we; baddr[c] = rf_waddr; bdata[c] = rf_wdata;
      bdone[c] = done; bfz[c] = flag_z; bfv[c] = flag_v;
      if (qc.size() < 3) begin
        start_valid = 1'b1;
        op_a = 8'($urandom); op_b = 8'($urandom);
        dst_lo = AW'($urandom); dst_hi = AW'($urandom);
        if (start_ready) begin
          qa.push_back(op_a); qb.push_back(op_b); ql.push_back(dst_lo); qh.push_back(dst_hi); qc.push_back(c);
        end
      end else begin
        start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    n_checks++;
    if (qc.size() != 3) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d exp 3", qc.size());
    end else begin
      n_checks++; if (qc[1] - qc[0] != 5 || qc[2] - qc[1] != 5) begin n_fail++; $display("FAIL b2b_interval: got %0d %0d exp 5 5", qc[1] - qc[0], qc[2] - qc[1]); end
      for (int c = 0; c < 24; c++) begin
        ew = 1'b0; ed = 1'b0; ea = '0; edat = 8'h00;
        for (int i = 0; i < 3; i++) begin
          p = 16'(qa[i]) * 16'(qb[i]);
          if (c == qc[i] + 2) begin ew = 1'b1; ea = ql[i]; edat = p[7:0]; end
          if (c == qc[i] + 3) begin ew = 1'b1; ea = qh[i]; edat = p[15:8]; end
          if (c == qc[i] + 4) begin
            ed = 1'b1;
            n_checks++; if (bfz[c] !== (p == 16'h0) || bfv[c] !== (p[15:8] != 8'h0)) begin n_fail++; $display("FAIL b2b_flags[%0d]: got z=%b v=%b for product %h", c, bfz[c], bfv[c], p); end
          end
        end
        n_checks++; if (bw[c] !== ew || bdone[c] !== ed) begin n_fail++; $display("FAIL b2b_ctl[%0d]: got we=%b done=%b exp %b %b", c, bw[c], bdone[c], ew, ed); end
        if (ew) begin
          n_checks++; if (baddr[c] !== ea || bdata[c] !== edat) begin n_fail++; $display("FAIL b2b_write[%0d]: got (%0d,%h) exp (%0d,%h)", c, baddr[c], bdata[c], ea, edat); end
        end
      end
      p = 16'(qa[2]) * 16'(qb[2]);
      prev_fz = (p == 16'h0); prev_fv = (p[15:8] != 8'h0);
    end
  endtask

  task automatic test_same_dst();
    do_op(8'd16, 8'd16, 3'd4, 3'd4, 0, 0);
    n_checks++; if (obs_we[2] !== 1'b1 || obs_addr[2] !== 3'd4 || obs_data[2] !== 8'h00) begin n_fail++; $display("FAIL same_dst_lo: got we=%b addr=%0d data=%h exp 1 4 00", obs_we[2], obs_addr[2], obs_data[2]); end
    n_checks++; if (obs_we[3] !== 1'b1 || obs_addr[3] !== 3'd4 || obs_data[3] !== 8'h01) begin n_fail++; $display("FAIL same_dst_hi: got we=%b addr=%0d data=%h exp 1 4 01", obs_we[3], obs_addr[3], obs_data[3]); end
    n_checks++; if (obs_done[4] !== 1'b1 || obs_fz[4] !== 1'b0 || obs_fv[4] !== 1'b1) begin n_fail++; $display("FAIL same_dst_done: got done=%b z=%b v=%b exp 1 0 1", obs_done[4], obs_fz[4], obs_fv[4]); end
    prev_fz = 1'b0; prev_fv = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0]    a, b;
    logic [AW-1:0] dl, dh;
    logic [15:0]   p;
    int            sl, sh, dk;
    logic          ew, ehi, efz, efv;
    for (int it = 0; it < 20; it++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (it == 3) a = 8'h00;
      dl = AW'($urandom); dh = AW'($urandom);
      sl = int'($urandom_range(0, 3)); sh = int'($urandom_range(0, 3));
      p  = 16'(a) * 16'(b);
      dk = 4 + sl + sh;
      do_op(a, b, dl, dh, sl, sh);
      for (int k = 0; k <= 6 + sl + sh; k++) begin
        ew  = (k >= 2) && (k <= 3 + sl + sh);
        ehi = (k >= 3 + sl);
        efz = (k >= dk) ? (p == 16'h0) : prev_fz;
        efv = (k >= dk) ? (p[15:8] != 8'h0) : prev_fv;
        n_checks++; if (obs_we[k] !== ew) begin n_fail++; $display("FAIL rnd%0d_we[%0d]: got %b exp %b", it, k, obs_we[k], ew); end
        if (ew) begin
          n_checks++;
          if (obs_addr[k] !== (ehi ? dh : dl) || obs_data[k] !== (ehi ? p[15:8] : p[7:0])) begin
            n_fail++; $display("FAIL rnd%0d_write[%0d]: got (%0d,%h) exp (%0d,%h)", it, k, obs_addr[k], obs_data[k], ehi ? dh : dl, ehi ? p[15:8] : p[7:0]);
          end
        end
        n_checks++; if (obs_done[k] !== (k == dk)) begin n_fail++; $display("FAIL rnd%0d_done[%0d]: got %b exp %b", it, k, obs_done[k], k == dk); end
        n_checks++; if (obs_rdy[k] !== ((k == 0) || (k > dk))) begin n_fail++; $display("FAIL rnd%0d_ready[%0d]: got %b exp %b", it, k, obs_rdy[k], (k == 0) || (k > dk)); end
        n_checks++; if (obs_fz[k] !== efz || obs_fv[k] !== efv) begin n_fail++; $display("FAIL rnd%0d_flags[%0d]: got z=%b v=%b exp %b %b", it, k, obs_fz[k], obs_fv[k], efz, efv); end
      end
      prev_fz = (p == 16'h0); prev_fv = (p[15:8] != 8'h0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_valid = 1'b1; op_a = 8'd9; op_b = 8'd9; dst_lo = 3'd1; dst_hi = 3'd2; rf_stall = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 8'h51) begin n_fail++; $display("FAIL rstmid_wr_lo: got we=%b addr=%0d data=%h exp 1 1 51", rf_we, rf_waddr, rf_wdata); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (rf_we !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_abort: got we=%b rdy=%b exp 0 1", rf_we, start_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (rf_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet[%0d]: got we=%b done=%b exp 0 0", i, rf_we, done); end
      n_checks++; if (flag_z !== 1'b0 || flag_v !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags[%0d]: got z=%b v=%b exp 0 0", i, flag_z, flag_v); end
    end
    prev_fz = 1'b0; prev_fv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0; dst_lo = '0; dst_hi = '0; rf_stall = 1'b0;
    test_reset();
    test_basic();
    test_zero_max();
    test_stall();
    test_back_to_back();
    test_same_dst();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
